dct_block_fetch: RTL and testbench

Upstream feeder for the 2D-DCT stage of the JPEG pipeline. It walks the input image SRAM (`MEM_IN`, 32768 x 64-bit, 8 pixels of 8 bits per word, raster order) in 8x8-block order. Each pixel is level-shifted by -128, and the block streams one 64-bit row per handshake to the DCT core. A small skid FIFO absorbs the 1-cycle SRAM read latency so backpressure from the DCT never loses data.

---
 rtl/dct_block_fetch.sv | 156 +++++++++++++++
 tb/tb_dct_block_fetch.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_block_fetch.sv
// Walks the input image SRAM in 8x8-block order, level-shifts each pixel by -128 and
// streams one 64-bit block row per handshake to the DCT core through a 2-entry skid FIFO.
module dct_block_fetch #(
    parameter int unsigned IMG_W_WORDS = 64,
    parameter int unsigned IMG_H_BLKS  = 64,
    parameter int unsigned AW          = 15
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    output logic          mem_rd_en_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic [63:0]   mem_rdata_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [63:0]   out_data_o,
    output logic [2:0]    out_row_o,
    output logic          out_blk_last_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int unsigned BcW = (IMG_W_WORDS > 1) ? $clog2(IMG_W_WORDS) : 1;
    localparam int unsigned BrW = (IMG_H_BLKS > 1) ? $clog2(IMG_H_BLKS) : 1;
    localparam logic [BcW-1:0] BcMax = BcW'(IMG_W_WORDS - 1);
    localparam logic [BrW-1:0] BrMax = BrW'(IMG_H_BLKS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e         state_q;
    logic [2:0]     r_q;
    logic [BcW-1:0] bc_q;
    logic [BrW-1:0] br_q;

    // Read issued last cycle; its tags wait here until the data lands.
    logic           inflight_q;
    logic [2:0]     infl_row_q;
    logic           infl_last_q;

    logic [63:0]    fifo_data_q [2];
    logic [2:0]     fifo_row_q  [2];
    logic           fifo_last_q [2];
    logic           wptr_q;
    logic           rptr_q;
    logic [1:0]     count_q;

    logic           pop;
    logic           last_word;
    logic [2:0]     occupancy;
    logic [1:0]     count_d;
    logic [63:0]    shifted;

    always_comb begin
        out_valid_o    = (count_q != 2'd0);
        out_data_o     = fifo_data_q[rptr_q];
        out_row_o      = fifo_row_q[rptr_q];
        out_blk_last_o = fifo_last_q[rptr_q];
        busy_o         = (state_q != StIdle);
        done_o         = (state_q == StDone);

        pop       = out_valid_o && out_ready_i;
        last_word = (r_q == 3'd7) && (bc_q == BcMax) && (br_q == BrMax);

        // Slots already committed after this cycle's pop; a new read needs one free.
        occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        mem_rd_en_o = (state_q == StRun) && (occupancy < 3'd2);
        count_d     = count_q + {1'b0, inflight_q} - {1'b0, pop};

        mem_addr_o = AW'(((32'(br_q) << 3) + 32'(r_q)) * IMG_W_WORDS + 32'(bc_q));

        // Flipping bit 7 of each byte is p - 128 in two's complement.
        shifted = mem_rdata_i ^ {8{8'h80}};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            r_q         <= '0;
            bc_q        <= '0;
            br_q        <= '0;
            inflight_q  <= 1'b0;
            infl_row_q  <= '0;
            infl_last_q <= 1'b0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            count_q     <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_row_q[i]  <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            inflight_q <= mem_rd_en_o;
            if (mem_rd_en_o) begin
                infl_row_q  <= r_q;
                infl_last_q <= last_word;
            end

            if (inflight_q) begin
                fifo_data_q[wptr_q] <= shifted;
                fifo_row_q[wptr_q]  <= infl_row_q;
                fifo_last_q[wptr_q] <= infl_last_q;
                wptr_q              <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            count_q <= count_d;

            // Row is the fastest index, then block column, then block row.
            if (mem_rd_en_o) begin
                if (r_q == 3'd7) begin
                    r_q <= '0;
                    if (bc_q == BcMax) begin
                        bc_q <= '0;
                        if (br_q == BrMax) begin
                            br_q <= '0;
                        end else begin
                            br_q <= br_q + 1'b1;
                        end
                    end else begin
                        bc_q <= bc_q + 1'b1;
                    end
                end else begin
                    r_q <= r_q + 3'd1;
                end
            end

            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (mem_rd_en_o && last_word) begin
                        state_q <= StDrain;
                    end
                end
                // Leave on the cycle of the final pop so done follows it by one cycle.
                StDrain: begin
                    if (count_d == 2'd0) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dct_block_fetch.sv
// Scoreboard bench for dct_block_fetch: a default-size instance and a 2x2-block instance
// share clock, reset and out_ready; a select bit routes start and observation.
module tb_dct_block_fetch;

    localparam int AW = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;
    logic ready;
    logic sel;

    int vectors = 0;
    int miscompares = 0;

    logic          start_b, rd_en_b, valid_b, last_b, busy_b, done_b;
    logic [AW-1:0] addr_b;
    logic [63:0]   rdata_b, data_b;
    logic [2:0]    row_b;

    logic          start_s, rd_en_s, valid_s, last_s, busy_s, done_s;
    logic [AW-1:0] addr_s;
    logic [63:0]   rdata_s, data_s;
    logic [2:0]    row_s;

    assign start_b = start & ~sel;
    assign start_s = start & sel;

    dct_block_fetch u_big (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start_b),
        .mem_rd_en_o    (rd_en_b),
        .mem_addr_o     (addr_b),
        .mem_rdata_i    (rdata_b),
        .out_valid_o    (valid_b),
        .out_ready_i    (ready),
        .out_data_o     (data_b),
        .out_row_o      (row_b),
        .out_blk_last_o (last_b),
        .busy_o         (busy_b),
        .done_o         (done_b)
    );

    dct_block_fetch #(
        .IMG_W_WORDS (2),
        .IMG_H_BLKS  (2),
        .AW          (AW)
    ) u_small (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start_s),
        .mem_rd_en_o    (rd_en_s),
        .mem_addr_o     (addr_s),
        .mem_rdata_i    (rdata_s),
        .out_valid_o    (valid_s),
        .out_ready_i    (ready),
        .out_data_o     (data_s),
        .out_row_o      (row_s),
        .out_blk_last_o (last_s),
        .busy_o         (busy_s),
        .done_o         (done_s)
    );

    // SRAM models: word i = {8{i[7:0]}}, one cycle read latency.
    always @(posedge clk) if (rd_en_b) rdata_b <= {8{addr_b[7:0]}};
    always @(posedge clk) if (rd_en_s) rdata_s <= {8{addr_s[7:0]}};

    logic          m_rd_en, m_valid, m_last, m_busy, m_done;
    logic [AW-1:0] m_addr;
    logic [63:0]   m_data;
    logic [2:0]    m_row;

    assign m_rd_en = sel ? rd_en_s : rd_en_b;
    assign m_addr  = sel ? addr_s  : addr_b;
    assign m_valid = sel ? valid_s : valid_b;
    assign m_data  = sel ? data_s  : data_b;
    assign m_row   = sel ? row_s   : row_b;
    assign m_last  = sel ? last_s  : last_b;
    assign m_busy  = sel ? busy_s  : busy_b;
    assign m_done  = sel ? done_s  : done_b;

    logic [AW-1:0] exp_addr_q [$];
    logic [63:0]   exp_data_q [$];
    logic [2:0]    exp_row_q  [$];
    logic          exp_last_q [$];
    logic [63:0]   obs_data   [512];

    task automatic run_pass(input bit use_small, input int ready_pct, input int restart_cyc,
                            input int abort_cyc);
        int w, h, total, cyc, issued, popped, dones, done_cyc, fall_cyc, end_cyc;
        logic [AW-1:0] ea;
        logic [63:0]   ed;
        logic [2:0]    er;
        logic          el;
        logic [7:0]    pix;
        w = use_small ? 2 : 64;
        h = use_small ? 2 : 64;
        total = 8 * w * h;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_row_q.delete();
        exp_last_q.delete();
        sel = use_small;
        for (int br = 0; br < h; br++) begin
            for (int bc = 0; bc < w; bc++) begin
                for (int r = 0; r < 8; r++) begin
                    ea  = AW'((br * 8 + r) * w + bc);
                    pix = ea[7:0] ^ 8'h80;
                    exp_addr_q.push_back(ea);
                    exp_data_q.push_back({8{pix}});
                    exp_row_q.push_back(3'(r));
                    exp_last_q.push_back(br == h - 1 && bc == w - 1 && r == 7);
                end
            end
        end
        @(negedge clk);
        start = 1'b1;
        ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; issued = 0; popped = 0; dones = 0;
        done_cyc = -1; fall_cyc = -1; end_cyc = -1;
        forever begin
            @(negedge clk);
            cyc++;
            ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
            start = (cyc == restart_cyc);
            if (cyc == abort_cyc) begin
                #2 rst_n = 1'b0;
                #1;
                vectors++;
                if ({m_rd_en, m_addr, m_valid, m_data, m_row, m_last, m_busy, m_done} !== '0) begin
                    miscompares++;
                    $display("FAIL async_reset_outputs: got rd=%b addr=%h v=%b data=%h row=%0d last=%b busy=%b done=%b required all 0",
                             m_rd_en, m_addr, m_valid, m_data, m_row, m_last, m_busy, m_done);
                end
                start = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    #1;
                    vectors++;
                    if (m_done !== 1'b0 || m_busy !== 1'b0) begin
                        miscompares++;
                        $display("FAIL no_done_after_abort: got done=%b busy=%b required 0 0",
                                 m_done, m_busy);
                    end
                end
                return;
            end
            #1;
            if (m_rd_en === 1'b1) begin
                issued++;
                vectors++;
                if (exp_addr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_read: got addr %h required no read", m_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (m_addr !== ea) begin
                        miscompares++;
                        $display("FAIL rd_addr: got %0d required %0d (cycle %0d)", m_addr, ea, cyc);
                    end
                end
            end
            if (m_valid === 1'b1 && ready === 1'b1) begin
                popped++;
                vectors++;
                if (exp_data_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_row: got data %h required nothing", m_data);
                end else begin
                    ed = exp_data_q.pop_front();
                    er = exp_row_q.pop_front();
                    el = exp_last_q.pop_front();
                    if (m_data !== ed || m_row !== er || m_last !== el) begin
                        miscompares++;
                        $display("FAIL out_row %0d: got data=%h row=%0d last=%b required data=%h row=%0d last=%b",
                                 popped - 1, m_data, m_row, m_last, ed, er, el);
                    end
                end
                if (!use_small && popped <= 512) obs_data[popped-1] = m_data;
                if (ready_pct >= 100 && (popped == 1 || popped == total)) begin
                    vectors++;
                    if (cyc != popped + 2) begin
                        miscompares++;
                        $display("FAIL row_cycle %0d: got cycle %0d required %0d",
                                 popped - 1, cyc, popped + 2);
                    end
                end
            end else if (m_valid === 1'b1 && exp_data_q.size() > 0) begin
                vectors++;
                if (m_data !== exp_data_q[0] || m_row !== exp_row_q[0]) begin
                    miscompares++;
                    $display("FAIL stall_hold: got data=%h row=%0d required data=%h row=%0d",
                             m_data, m_row, exp_data_q[0], exp_row_q[0]);
                end
            end
            vectors++;
            if (issued - popped > 2) begin
                miscompares++;
                $display("FAIL outstanding: got %0d required <= 2", issued - popped);
            end
            if (m_done === 1'b1) begin
                dones++;
                done_cyc = cyc;
            end
            if (fall_cyc < 0 && dones > 0 && m_busy === 1'b0) begin
                fall_cyc = cyc;
                end_cyc = cyc + 5;
            end
            if (cyc == end_cyc) break;
            if (cyc > 8 * total + 200) begin
                vectors++;
                miscompares++;
                $display("FAIL timeout: got no completion after %0d cycles required done", cyc);
                break;
            end
        end
        vectors++;
        if (dones != 1 || exp_data_q.size() != 0 || exp_addr_q.size() != 0) begin
            miscompares++;
            $display("FAIL pass_complete: got dones=%0d rows_left=%0d reads_left=%0d required 1 0 0",
                     dones, exp_data_q.size(), exp_addr_q.size());
        end
        if (ready_pct >= 100) begin
            vectors++;
            if (done_cyc != total + 3 || fall_cyc != total + 4) begin
                miscompares++;
                $display("FAIL done_timing: got done=%0d busy_fall=%0d required %0d %0d",
                         done_cyc, fall_cyc, total + 3, total + 4);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            vectors++;
            if ({m_rd_en, m_addr, m_valid, m_data, m_row, m_last, m_busy, m_done} !== '0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: got rd=%b addr=%h v=%b data=%h row=%0d last=%b busy=%b done=%b required all 0",
                         s, m_rd_en, m_addr, m_valid, m_data, m_row, m_last, m_busy, m_done);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_default_stream();
        run_pass(1'b0, 100, -1, -1);
    endtask

    task automatic test_pixels();
        logic [63:0] want [5];
        int          idx  [5];
        idx[0] = 0;   want[0] = 64'h8080808080808080;
        idx[1] = 1;   want[1] = 64'hc0c0c0c0c0c0c0c0;
        idx[2] = 2;   want[2] = 64'h0000000000000000;
        idx[3] = 8;   want[3] = 64'h8181818181818181;
        idx[4] = 507; want[4] = 64'h7f7f7f7f7f7f7f7f;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (obs_data[idx[i]] !== want[i]) begin
                miscompares++;
                $display("FAIL pixel_row %0d: got %h required %h", idx[i], obs_data[idx[i]], want[i]);
            end
        end
    endtask

    task automatic test_small_order();
        run_pass(1'b1, 100, -1, -1);
    endtask

    task automatic test_random_ready();
        repeat (3) run_pass(1'b1, 50, -1, -1);
    endtask

    task automatic test_restart_ignored();
        run_pass(1'b1, 100, 5, -1);
        run_pass(1'b1, 50, 12, -1);
    endtask

    task automatic test_reset_mid_pass();
        run_pass(1'b0, 100, -1, 100);
        run_pass(1'b0, 50, -1, 40);
        run_pass(1'b1, 100, -1, -1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        sel   = 1'b0;
        test_reset();
        test_default_stream();
        test_pixels();
        test_small_order();
        test_random_ready();
        test_restart_ignored();
        test_reset_mid_pass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
